// File: rtl/fifo_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_tx_pkg
// Shared types and constants for the FIFO-fed serial transmitter.
//   state_t     : transmitter FSM state encoding
//   IDLE_LEVEL  : level driven on the serial line when no frame is in flight
// Optional feature macro: FIFO_TX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package fifo_tx_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_tx_baud.sv
// -----------------------------------------------------------------------------
// fifo_tx_baud
// Bit-period timer: counts 0..div-1 while enabled and wraps, flagging the last
// cycle of every serial bit.
//   clk     : clock
//   rst     : synchronous active-low reset
//   en      : count enable (a frame is in progress); counter held at 0 otherwise
//   bit_end : one-cycle tick on the last cycle of the current bit
// -----------------------------------------------------------------------------
module fifo_tx_baud #(
  parameter int div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_end
);

  // A 1-bit counter still exists for div=1; it simply stays at 0.
  localparam int            CW   = (div > 1) ? $clog2(div) : 1;
  localparam logic [CW-1:0] LAST = CW'(div - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// fifo_tx_serializer
// Pops words from an upstream FIFO and sends each as a serial frame:
// start bit (0), data bits LSB first, optional even-parity bit, stop bit (1).
// Each bit lasts div clock cycles. Back-to-back frames are issued without an
// idle gap when the FIFO still holds data on the last stop cycle.
// Parameters: bits (data word width), div (clock cycles per serial bit, >= 1).
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   fifo_dout  : FIFO head word, valid while fifo_pndng=1
//   fifo_pndng : FIFO not empty
//   fifo_pop   : one-cycle pop pulse; the head word is captured in that cycle
//   tx         : serial output, idles high
//   busy       : frame in progress
//   frame_done : one-cycle pulse on the last stop-bit cycle
// Optional feature macro: FIFO_TX_PARITY_EN (even parity bit after the data).
// -----------------------------------------------------------------------------
module fifo_tx_serializer #(
  parameter int bits = 8,
  parameter int div  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] fifo_dout,
  input  logic            fifo_pndng,
  output logic            fifo_pop,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  import fifo_tx_pkg::*;

  localparam int            BW       = (bits > 1) ? $clog2(bits) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(bits - 1);

  state_t          state, state_next;
  logic [bits-1:0] shreg;
  logic [BW-1:0]   bit_cnt;
  logic            bit_end;
  logic            load;
`ifdef FIFO_TX_PARITY_EN
  logic            par;
`endif

  assign busy     = (state != IDLE);
  assign fifo_pop = load;

  fifo_tx_baud #(.div(div)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .bit_end (bit_end)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (fifo_pndng) begin
                load       = 1'b1;
                state_next = START;
              end
      START:  if (bit_end) state_next = DATA;
`ifdef FIFO_TX_PARITY_EN
      DATA:   if (bit_end && bit_cnt == LAST_BIT) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:   if (bit_end && bit_cnt == LAST_BIT) state_next = STOP;
`endif
      STOP:   if (bit_end) begin
                frame_done = 1'b1;
                // Chain straight into the next start bit when data is waiting.
                if (fifo_pndng) begin
                  load       = 1'b1;
                  state_next = START;
                end else begin
                  state_next = IDLE;
                end
              end
      default: state_next = IDLE;
    endcase
    // A reset cycle must never consume a word or announce a completed frame.
    if (!rst) begin
      load       = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_comb begin
    tx = IDLE_LEVEL;
    case (state)
      START:  tx = ~IDLE_LEVEL;
      DATA:   tx = shreg[0];
`ifdef FIFO_TX_PARITY_EN
      PARITY: tx = par;
`endif
      default: ;
    endcase
  end

  // NOTE: the shift register is cleared on reset as well as the control
  // state, so nothing of an aborted word survives into the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef FIFO_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (load) begin
        shreg   <= fifo_dout;
        bit_cnt <= '0;
`ifdef FIFO_TX_PARITY_EN
        // Parity is taken from the whole word before shifting destroys it.
        par     <= ^fifo_dout;
`endif
      end else if (state == DATA && bit_end) begin
        shreg   <= shreg >> 1;
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_tx_serializer
// Bench for fifo_tx_serializer: a queue-backed FIFO model feeds the main DUT
// (bits=8, div=4); each observed pop expands the popped word into a per-cycle
// expectation of {tx, busy, frame_done} that is checked on every falling edge.
// A second instance with div=1 is exercised with a directed single frame.
// Honours FIFO_TX_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_fifo_tx_serializer;

  localparam int BITS = 8;
  localparam int DIV  = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (2 + BITS + P) * DIV;
  localparam int LEN1  = 2 + BITS + P;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] fifo_dout  = '0;
  logic       fifo_pndng = 1'b0;
  logic       fifo_pop, tx, busy, frame_done;
  logic [7:0] dout1  = '0;
  logic       pndng1 = 1'b0;
  logic       pop1, tx1, busy1, done1;

  always #5 clk = ~clk;

  fifo_tx_serializer #(.bits(BITS), .div(DIV)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_pndng(fifo_pndng),
    .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_tx_serializer #(.bits(BITS), .div(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_dout(dout1), .fifo_pndng(pndng1),
    .fifo_pop(pop1), .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus FIFO contents and per-cycle expectations {tx, busy, frame_done}.
  logic [7:0] fifo_q[$];
  logic [2:0] exp_q[$];
  int         pop_log[$];
  int         done_log[$];
  bit         pop_pending = 1'b0;
  int         cyc = 0;
  int         last_pop_cyc = 0;
  int         last_rst_cyc = 0;
  logic [2:0] e;
  logic       exp_pop;

  function automatic void push_frame(input logic [7:0] w);
    for (int i = 0; i < DIV; i++) exp_q.push_back(3'b010);
    for (int b = 0; b < BITS; b++)
      for (int i = 0; i < DIV; i++) exp_q.push_back({w[b], 2'b10});
    if (P == 1)
      for (int i = 0; i < DIV; i++) exp_q.push_back({^w, 2'b10});
    for (int i = 0; i < DIV; i++) exp_q.push_back({2'b11, (i == DIV - 1)});
  endfunction

  // Monitor: sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("rst_pop", fifo_pop, 1'b0);
      check("rst_done", frame_done, 1'b0);
      exp_q.delete();
      last_rst_cyc = cyc;
    end else begin
      e = (exp_q.size() == 0) ? 3'b100 : exp_q.pop_front();
      check("line_tx_busy_done", {tx, busy, frame_done}, e);
      exp_pop = fifo_pndng && (e == 3'b100 || e[0]);
      check("pop", fifo_pop, exp_pop);
      if (frame_done) begin
        check("frame_len", cyc - last_pop_cyc, FRAME);
        done_log.push_back(cyc);
      end
      if (fifo_pop) begin
        if (fifo_q.size() != 0) push_frame(fifo_q[0]);
        last_pop_cyc = cyc;
        pop_log.push_back(cyc);
        pop_pending = 1'b1;
      end
    end
  end

  // FIFO model: retire a popped word after the capturing edge, then present
  // the new head (garbage data while empty).
  always @(posedge clk) begin
    #2;
    if (pop_pending) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_pending = 1'b0;
    end
    fifo_pndng = (fifo_q.size() != 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  end

  task automatic send(input logic [7:0] w);
    @(posedge clk);
    #1;
    fifo_q.push_back(w);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || pop_pending) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  function automatic logic d1_exp(input logic [7:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= BITS) return w[i-1];
    if (P == 1 && i == BITS + 1) return ^w;
    return 1'b1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0, d0, n;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_pop", fifo_pop, 1'b0);
    check("reset_done", frame_done, 1'b0);
    rst = 1'b1;

    // Single word 0xA5.
    p0 = pop_log.size();
    send(8'hA5);
    wait_drain(200);
    check("single_pops", pop_log.size() - p0, 1);

    // Back-to-back 0x01 then 0xFF.
    p0 = pop_log.size();
    d0 = done_log.size();
    send(8'h01);
    fifo_q.push_back(8'hFF);
    wait_drain(300);
    check("b2b_pops", pop_log.size() - p0, 2);
    check("b2b_dones", done_log.size() - d0, 2);
    if (pop_log.size() - p0 == 2 && done_log.size() - d0 == 2) begin
      check("b2b_pop_on_done", pop_log[p0+1], done_log[d0]);
      check("b2b_total", done_log[d0+1] - pop_log[p0], 2 * FRAME);
    end

    // Random words with random gaps (some overlap a frame in flight).
    for (int k = 0; k < 5; k++) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    wait_drain(1000);

    // Reset mid-frame with another word waiting.
    p0 = pop_log.size();
    d0 = done_log.size();
    send(8'h96);
    n = 0;
    while (pop_log.size() == p0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_test_first_pop", pop_log.size() - p0, 1);
    send(8'h3C);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_drain(300);
    check("rst_test_pops", pop_log.size() - p0, 2);
    check("rst_test_dones", done_log.size() - d0, 1);
    check("rst_test_repop", pop_log[pop_log.size()-1], last_rst_cyc + 1);

    // Empty FIFO for 100 cycles.
    p0 = pop_log.size();
    repeat (100) @(negedge clk);
    #1;
    check("empty_pops", pop_log.size() - p0, 0);

    // div=1 instance, word 0x80.
    @(posedge clk);
    #1;
    dout1  = 8'h80;
    pndng1 = 1'b1;
    @(negedge clk);
    check("d1_pop", pop1, 1'b1);
    check("d1_idle_busy", busy1, 1'b0);
    @(posedge clk);
    #1;
    pndng1 = 1'b0;
    dout1  = 8'h7F;
    for (int i = 0; i < LEN1; i++) begin
      @(negedge clk);
      check("d1_tx", tx1, d1_exp(8'h80, i));
      check("d1_busy", busy1, 1'b1);
      check("d1_done", done1, (i == LEN1 - 1));
      check("d1_no_pop", pop1, 1'b0);
    end
    @(negedge clk);
    check("d1_busy_after", busy1, 1'b0);
    check("d1_tx_after", tx1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
